// File: rtl/mem_resp_pkg.sv
// Shared types for the GPU data-memory responder.
// Latency: n/a. Backpressure: n/a.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

endpackage

// File: rtl/data_mem_responder_arb.sv
// Round-robin pick of the first requester at or after ptr; purely combinational.
// Latency: 0 cycles. Backpressure: none, grant is advisory to the caller.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);

  logic w_found;

  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && req[(int'(ptr) + i) % N]) begin
        w_found                     = 1'b1;
        grant[(int'(ptr) + i) % N]  = 1'b1;
        idx                         = PW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Round-robin GPU data-memory responder on one single-port array, host preload port.
// Latency: ready LATENCY cycles after grant edge; one request in flight, others wait.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int CHANNELS  = 4,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [CHANNELS-1:0]                  read_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]   read_address,
  output logic [CHANNELS-1:0]                  read_ready,
  output logic [CHANNELS-1:0][DATA_BITS-1:0]   read_data,
  input  logic [CHANNELS-1:0]                  write_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]   write_address,
  input  logic [CHANNELS-1:0][DATA_BITS-1:0]   write_data,
  output logic [CHANNELS-1:0]                  write_ready,
  input  logic                                 host_write_enable,
  input  logic [ADDR_BITS-1:0]                 host_address,
  input  logic [DATA_BITS-1:0]                 host_write_data,
  output logic [DATA_BITS-1:0]                 host_read_data,
  output logic                                 host_busy,
  output logic                                 busy
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  function automatic logic in_range(input logic [ADDR_BITS-1:0] a);
    return ({1'b0, a} < (ADDR_BITS+1)'(DEPTH));
  endfunction

  state_t                               r_state;
  op_t                                  r_op;
  logic [CW-1:0]                        r_ch;
  logic [CW-1:0]                        r_ptr;
  logic [ADDR_BITS-1:0]                 r_addr;
  logic [DATA_BITS-1:0]                 r_wdata;
  logic [LW-1:0]                        r_cnt;
  logic [CHANNELS-1:0]                  r_rd_served;
  logic [CHANNELS-1:0]                  r_wr_served;
  logic [CHANNELS-1:0]                  r_read_ready;
  logic [CHANNELS-1:0]                  r_write_ready;
  logic [CHANNELS-1:0][DATA_BITS-1:0]   r_read_data;
  logic [DATA_BITS-1:0]                 r_host_rd;
  logic                                 r_busy;
  logic [DATA_BITS-1:0]                 r_mem [DEPTH];

  logic [CHANNELS-1:0] w_rd_req;
  logic [CHANNELS-1:0] w_wr_req;
  logic [CHANNELS-1:0] w_gnt;
  logic [CW-1:0]       w_idx;
  logic                w_any;
  logic                w_gnt_wr;
  logic                w_commit;
  logic                w_host_we;

  // Served flags are per op so a pending read behind a same-channel write stays eligible.
  assign w_rd_req  = read_valid  & ~r_rd_served;
  assign w_wr_req  = write_valid & ~r_wr_served;
  assign w_any     = |(w_rd_req | w_wr_req);
  assign w_gnt_wr  = |(w_gnt & w_wr_req);
  assign w_commit  = (r_state == ACCESS) && (r_cnt == '0);
  assign w_host_we = host_write_enable && reset && (r_state == IDLE) && !w_any;

  rr_arbiter #(
    .N  (CHANNELS),
    .PW (CW)
  ) u_arb (
    .req   (w_rd_req | w_wr_req),
    .ptr   (r_ptr),
    .grant (w_gnt),
    .idx   (w_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_op          <= OP_READ;
      r_ch          <= '0;
      r_ptr         <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_cnt         <= '0;
      r_rd_served   <= '0;
      r_wr_served   <= '0;
      r_read_ready  <= '0;
      r_write_ready <= '0;
      r_read_data   <= '0;
      r_busy        <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (!read_valid[c] && !write_valid[c]) begin
          r_rd_served[c] <= 1'b0;
          r_wr_served[c] <= 1'b0;
        end
      end
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_ch    <= w_idx;
            r_op    <= w_gnt_wr ? OP_WRITE : OP_READ;
            r_addr  <= w_gnt_wr ? write_address[w_idx] : read_address[w_idx];
            r_wdata <= write_data[w_idx];
            r_cnt   <= LW'(LATENCY - 1);
            r_ptr   <= (w_idx == CW'(CHANNELS - 1)) ? '0 : w_idx + CW'(1);
            r_busy  <= 1'b1;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            if (r_op == OP_READ) begin
              r_read_data[r_ch]  <= in_range(r_addr) ? r_mem[r_addr[IW-1:0]] : '0;
              r_read_ready[r_ch] <= 1'b1;
              r_rd_served[r_ch]  <= 1'b1;
            end else begin
              r_write_ready[r_ch] <= 1'b1;
              r_wr_served[r_ch]   <= 1'b1;
            end
            r_state <= RESPOND;
          end else begin
            r_cnt <= r_cnt - LW'(1);
          end
        end
        RESPOND: begin
          r_read_ready  <= '0;
          r_write_ready <= '0;
          r_busy        <= 1'b0;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately left without reset so preloaded contents survive it.
  always_ff @(posedge clk) begin
    if (w_commit && (r_op == OP_WRITE) && in_range(r_addr)) begin
      r_mem[r_addr[IW-1:0]] <= r_wdata;
    end else if (w_host_we && in_range(host_address)) begin
      r_mem[host_address[IW-1:0]] <= host_write_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_host_rd <= '0;
    end else begin
      r_host_rd <= in_range(host_address) ? r_mem[host_address[IW-1:0]] : '0;
    end
  end

  assign read_ready     = r_read_ready;
  assign write_ready    = r_write_ready;
  assign read_data      = r_read_data;
  assign host_read_data = r_host_rd;
  assign host_busy      = r_busy;
  assign busy           = r_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DEPTH=16, LATENCY=2, 4 channels).
module tb_data_mem_responder;

  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int CH  = 4;
  localparam int DEP = 16;
  localparam int LAT = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [CH-1:0]            read_valid;
  logic [CH-1:0][AB-1:0]    read_address;
  logic [CH-1:0]            read_ready;
  logic [CH-1:0][DB-1:0]    read_data;
  logic [CH-1:0]            write_valid;
  logic [CH-1:0][AB-1:0]    write_address;
  logic [CH-1:0][DB-1:0]    write_data;
  logic [CH-1:0]            write_ready;
  logic                     host_write_enable;
  logic [AB-1:0]            host_address;
  logic [DB-1:0]            host_write_data;
  logic [DB-1:0]            host_read_data;
  logic                     host_busy;
  logic                     busy;

  int total = 0;
  int bad   = 0;
  int n;
  int p;

  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_BITS (AB),
    .DATA_BITS (DB),
    .CHANNELS  (CH),
    .DEPTH     (DEP),
    .LATENCY   (LAT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .read_valid        (read_valid),
    .read_address      (read_address),
    .read_ready        (read_ready),
    .read_data         (read_data),
    .write_valid       (write_valid),
    .write_address     (write_address),
    .write_data        (write_data),
    .write_ready       (write_ready),
    .host_write_enable (host_write_enable),
    .host_address      (host_address),
    .host_write_data   (host_write_data),
    .host_read_data    (host_read_data),
    .host_busy         (host_busy),
    .busy              (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [AB-1:0] a, input logic [DB-1:0] d);
    host_write_enable = 1'b1;
    host_address      = a;
    host_write_data   = d;
    tick();
    host_write_enable = 1'b0;
  endtask

  task automatic host_rd_chk(input string tag, input logic [AB-1:0] a, input logic [DB-1:0] exp);
    host_address = a;
    tick();
    chk(tag, host_read_data, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset             = 1'b0;
    read_valid        = '0;
    write_valid       = '0;
    read_address      = '0;
    write_address     = '0;
    write_data        = '0;
    host_write_enable = 1'b0;
    host_address      = '0;
    host_write_data   = '0;
    tick();
    tick();
    chk("rst_rdy", {read_ready, write_ready}, 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_hrd", host_read_data, 0);
    chk("rst_busy", {host_busy, busy}, 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) host_wr(AB'(i), DB'((i % 4) + 1));
    host_wr(8'd9, 8'h33);
    host_rd_chk("pre_a3", 8'd3, 8'd4);
    host_rd_chk("pre_a9", 8'd9, 8'h33);

    // single read, LATENCY=2: ready on the third cycle after valid is raised
    read_address[0] = 8'd3;
    read_valid[0]   = 1'b1;
    tick();
    chk("t1_busy", busy, 1);
    chk("t1_rdy_c1", {read_ready, write_ready}, 0);
    tick();
    chk("t1_rdy_c2", {read_ready, write_ready}, 0);
    tick();
    chk("t1_rr", read_ready, 4'b0001);
    chk("t1_wr", write_ready, 0);
    chk("t1_data", read_data[0], 8'd4);
    read_valid = '0;
    tick();
    chk("t1_drop", read_ready, 0);
    chk("t1_hold", read_data[0], 8'd4);
    chk("t1_idle", busy, 0);

    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // four simultaneous reads from pointer 0: ch0..ch3, one every 4 cycles
    for (int c = 0; c < CH; c++) read_address[c] = AB'(c);
    read_valid = 4'hF;
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (read_ready != 0) begin
        chk("t2_vec", read_ready, 32'd1 << (n % CH));
        chk("t2_cyc", c, 3 + 4 * n);
        chk("t2_data", read_data[n % CH], n + 1);
        n++;
      end
    end
    chk("t2_cnt", n, 4);
    read_valid = '0;
    tick();
    tick();

    // same-channel write then read of the same address
    write_address[1] = 8'd8;
    write_data[1]    = 8'd7;
    read_address[1]  = 8'd8;
    write_valid[1]   = 1'b1;
    read_valid[1]    = 1'b1;
    p = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      p += $countones({read_ready, write_ready});
      if (c == 3) chk("t3_wr", {read_ready, write_ready}, 8'b0000_0010);
      if (c == 7) begin
        chk("t3_rd", {read_ready, write_ready}, 8'b0010_0000);
        chk("t3_data", read_data[1], 8'd7);
      end
    end
    chk("t3_pulses", p, 2);
    chk("t3_busy", busy, 0);
    read_valid  = '0;
    write_valid = '0;
    tick();

    // held valid is served once; a one-cycle drop re-arms it
    read_address[2] = 8'd5;
    read_valid[2]   = 1'b1;
    tick();
    tick();
    tick();
    chk("t4_rr1", read_ready, 4'b0100);
    chk("t4_d1", read_data[2], 8'd2);
    p = 0;
    repeat (5) begin
      tick();
      p += $countones({read_ready, write_ready});
    end
    chk("t4_held", p, 0);
    chk("t4_busy", busy, 0);
    read_valid[2] = 1'b0;
    tick();
    read_address[2] = 8'd6;
    read_valid[2]   = 1'b1;
    tick();
    tick();
    chk("t4_pre", read_ready, 0);
    tick();
    chk("t4_rr2", read_ready, 4'b0100);
    chk("t4_d2", read_data[2], 8'd3);
    read_valid = '0;
    tick();

    // reset during ACCESS of a write: no commit, outputs drop
    write_address[0] = 8'd9;
    write_data[0]    = 8'd55;
    write_valid[0]   = 1'b1;
    tick();
    chk("t5_busy", busy, 1);
    reset = 1'b0;
    #2;
    chk("t5_rdy", {read_ready, write_ready}, 0);
    chk("t5_busy0", {host_busy, busy}, 0);
    chk("t5_rdata", read_data, 0);
    tick();
    write_valid = '0;
    reset       = 1'b1;
    tick();
    chk("t5_wr", write_ready, 0);
    host_rd_chk("t5_mem9", 8'd9, 8'h33);

    // out-of-range read returns 0; out-of-range write dropped (17 would alias 1)
    read_address[0] = 8'd1;
    read_valid[0]   = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_d1", read_data[0], 8'd2);
    read_valid = '0;
    tick();
    read_address[0] = 8'd20;
    read_valid[0]   = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_rr", read_ready, 4'b0001);
    chk("t6_d0", read_data[0], 8'd0);
    read_valid = '0;
    tick();
    write_address[0] = 8'd17;
    write_data[0]    = 8'd99;
    write_valid[0]   = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_wr", write_ready, 4'b0001);
    write_valid = '0;
    tick();
    host_rd_chk("t6_mem1", 8'd1, 8'd2);

    // host writes lose to a same-cycle grant and are ignored while busy
    host_write_enable = 1'b1;
    host_address      = 8'd4;
    host_write_data   = 8'hBB;
    read_address[3]   = 8'd0;
    read_valid[3]     = 1'b1;
    tick();
    chk("t7_hbusy1", host_busy, 1);
    host_address    = 8'd2;
    host_write_data = 8'hAA;
    tick();
    chk("t7_hbusy2", host_busy, 1);
    tick();
    chk("t7_rr", read_ready, 4'b1000);
    chk("t7_d", read_data[3], 8'd1);
    host_write_enable = 1'b0;
    read_valid        = '0;
    tick();
    chk("t7_hbusy0", host_busy, 0);
    host_rd_chk("t7_mem4", 8'd4, 8'd1);
    host_rd_chk("t7_mem2", 8'd2, 8'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Synthesizable RTL responder for the GPU data-memory channel protocol (read_valid/read_address → read_ready/read_data, write_valid/write_address/write_data → write_ready). It replaces the behavioural memory model in benches and FPGA builds. The block arbitrates all GPU channels round-robin onto one single-port storage array with configurable access latency. A host port preloads and inspects contents while idle.

Parameters:
ADDR_BITS, 8, address width per channel
DATA_BITS, 8, word width
CHANNELS, 4, number of GPU request channels
DEPTH, 256, storage words (≤ 2^ADDR_BITS)
LATENCY, 2, cycles from grant to response (≥1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low (asserted when 0)
read_valid  in  CHANNELS  per-channel read request
read_address  in  CHANNELS x ADDR_BITS  read addresses
read_ready  out  CHANNELS  one-cycle read response strobe
read_data  out  CHANNELS x DATA_BITS  read data, valid while read_ready
write_valid  in  CHANNELS  per-channel write request
write_address  in  CHANNELS x ADDR_BITS  write addresses
write_data  in  CHANNELS x DATA_BITS  write data
write_ready  out  CHANNELS  one-cycle write acknowledge
host_write_enable  in  1  host preload write
host_address  in  ADDR_BITS  host address
host_write_data  in  DATA_BITS  host write data
host_read_data  out  DATA_BITS  registered mem[host_address], updated every cycle
host_busy  out  1  high when state ≠ IDLE; host writes ignored
busy  out  1  request in flight

Behaviour:
- Reset values: read_ready=0, write_ready=0, read_data=0, host_read_data=0, host_busy=0, busy=0, state IDLE, RR pointer 0, served flags clear. Storage is NOT reset.
- States: IDLE → ACCESS → RESPOND → IDLE.
- IDLE: a channel is eligible if (read_valid|write_valid) and its served flag is clear. Pick the first eligible channel at/after the RR pointer. At the edge: latch channel, op, address, data; load counter=LATENCY-1; go ACCESS. RR pointer ← granted+1 mod CHANNELS.
- Same-channel read and write both valid: write is granted first. The read is granted on a later arbitration, not skipping the RR order.
- ACCESS: decrement the counter. At the edge where counter==0, perform the array access: a write commits; a read registers mem[addr] into that channel's read_data. Then go RESPOND. Result: ready is high in the cycle after grant edge + LATENCY edges.
- RESPOND: exactly one of read_ready/write_ready is high for the granted channel, for one cycle. The channel's served flag is set. Return to IDLE.
- Served flag clears on the first cycle that channel has both valids low. The channel is ineligible while the flag is set, so a held valid is never re-served. Exception: a pending second op (read after write) is eligible; the flag is tracked per op.
- read_data holds its last value when not ready.
- Address/data changes or a valid drop during ACCESS: the latched request still completes and ready still pulses.
- Address ≥ DEPTH: read returns 0; write is dropped; ready still pulses.
- Host: write only in IDLE with no grant that cycle; GPU grant takes priority. host_read_data latency is 1 cycle.
- Reset asserted mid-ACCESS: abort immediately. No commit occurs if it arrives before the access edge. Ready outputs drop to 0.

Decomposition:
- Package mem_resp_pkg: state enum (IDLE, ACCESS, RESPOND) and op enum (OP_READ, OP_WRITE).
- Sub-module rr_arbiter: parameter N; inputs request vector and pointer; outputs one-hot grant and index. Combinational, instantiated once.

Test Plan:
- Host preload addr 0–7 = {1,2,3,4,1,2,3,4}; ch0 reads addr 3, LATENCY=2 → read_ready[0] one-cycle pulse 2 cycles after grant, read_data[0]=4; no other ready.
- ch0–3 read addr 0,1,2,3 simultaneously → responses in order ch0,1,2,3, data 1,2,3,4, one pulse each, no overlap.
- ch1 writes addr 8=7 and reads addr 8 in the same cycle → write_ready[1] first, then read_ready[1] with data 7.
- ch2 holds read_valid 5 cycles after ready → only one read_ready pulse; drop valid 1 cycle, reassert → a second pulse.
- Reset low during ACCESS of write addr 9=55 → all ready stay 0; after release, host reads addr 9 and sees its unchanged old value.
- DEPTH=16: ch0 reads addr 20 → data 0 with ready pulse. Host write during busy → host_busy=1 and storage unchanged.
